// File: rtl/freq_pkg.sv
// Shared encodings and default widths for the frequency-counter path.
// Used by the measurement scheduler and the counter/CDC chain it drives.
package freq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        GATE    = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        PRESENT = 3'd5
    } state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CH_W      = 2;
    localparam int DEF_CNTR_SIZE = 10;
    localparam int DEF_GATE_W    = 16;
    localparam int DEF_SETTLE    = 4;

endpackage

// File: rtl/freq_rr_picker.sv
// Round-robin channel picker: first set mask bit strictly after ptr,
// wrapping; ptr itself is chosen only when it is the sole set bit.
module freq_rr_picker #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   nxt,
    output logic              any
);

    always_comb begin
        logic [CH_W-1:0] idx;
        idx = '0;
        nxt = ptr;
        any = |mask;
        // Scan farthest offset first so the nearest hit wins.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
    end

endmodule

// File: rtl/freq_gate_sequencer.sv
// Time-shares one counter/CDC chain across measured clocks: per channel
// it clears, gates, waits for the count to settle, captures and presents.
module freq_gate_sequencer
    import freq_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CH_W          = DEF_CH_W,
    parameter int CNTR_SIZE     = DEF_CNTR_SIZE,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [GATE_W-1:0]    gate_len,
    output logic [CH_W-1:0]      ch_sel,
    output logic                 cntr_clr,
    output logic                 gate,
    input  logic [CNTR_SIZE-1:0] count_in,
    input  logic                 count_ovf_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CH_W-1:0]      res_ch,
    output logic [CNTR_SIZE-1:0] res_count,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);

    state_t              state, state_n;
    logic [CH_W-1:0]     ptr, ptr_n;
    logic [CH_W-1:0]     ch_sel_n;
    logic [GATE_W-1:0]   gcnt, gcnt_n;
    logic [SW-1:0]       scnt, scnt_n;
    logic [CH_W-1:0]     pick;
    logic                any;
    logic                pick_go;

    freq_rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .mask (ch_mask),
        .ptr  (ptr),
        .nxt  (pick),
        .any  (any)
    );

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        ch_sel_n = ch_sel;
        gcnt_n   = gcnt;
        scnt_n   = '0;
        pick_go  = 1'b0;
        unique case (state)
            IDLE: begin
                pick_go = enable && any;
            end
            CLEAR: begin
                if (!enable) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n  = (gate_len == '0) ? GATE_W'(1) : gate_len;
                    state_n = GATE;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (gcnt == GATE_W'(1)) begin
                    state_n = SETTLE;
                end else begin
                    gcnt_n = gcnt - GATE_W'(1);
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (scnt == S_LAST) begin
                    state_n = CAPTURE;
                end else begin
                    scnt_n = scnt + SW'(1);
                end
            end
            CAPTURE: begin
                state_n = PRESENT;
            end
            PRESENT: begin
                if (res_ready) begin
                    pick_go = enable && any;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (pick_go) begin
            state_n  = CLEAR;
            ch_sel_n = pick;
            ptr_n    = pick;
        end
    end

    // Outputs are flopped from the next state so they align with it.
    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= CH_W'(NUM_CH - 1);
            ch_sel    <= '0;
            gcnt      <= '0;
            scnt      <= '0;
            cntr_clr  <= 1'b0;
            gate      <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            res_ch    <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            ch_sel    <= ch_sel_n;
            gcnt      <= gcnt_n;
            scnt      <= scnt_n;
            cntr_clr  <= (state_n == CLEAR);
            gate      <= (state_n == GATE);
            res_valid <= (state_n == PRESENT);
            busy      <= (state_n != IDLE);
            if (state == CAPTURE) begin
                res_ch    <= ch_sel;
                res_count <= count_in;
                res_ovf   <= count_ovf_in;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Scoreboard bench for freq_gate_sequencer with directed scenarios.
module tb_freq_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] ch_mask;
    logic [15:0] gate_len;
    logic [1:0] ch_sel;
    logic       cntr_clr;
    logic       gate;
    logic [9:0] count_in;
    logic       count_ovf_in;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_ch;
    logic [9:0] res_count;
    logic       res_ovf;
    logic       busy;
    logic       ovf_force;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ch;
        logic [9:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    freq_gate_sequencer dut (
        .clk_ref      (clk),
        .rst          (rst),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .gate_len     (gate_len),
        .ch_sel       (ch_sel),
        .cntr_clr     (cntr_clr),
        .gate         (gate),
        .count_in     (count_in),
        .count_ovf_in (count_ovf_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_ch       (res_ch),
        .res_count    (res_count),
        .res_ovf      (res_ovf),
        .busy         (busy)
    );

    function automatic logic [9:0] base(input logic [1:0] c);
        return 10'(100 + 7 * int'(c));
    endfunction

    // Shared counter model: per-channel count, noise while presenting.
    always @(negedge clk) begin
        if (res_valid) count_in = 10'($urandom);
        else count_in = base(ch_sel);
        count_ovf_in = ovf_force && (ch_sel == 2'd3);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic o);
        exp_t e;
        e.ch = c;
        e.cnt = base(c);
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int bound, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < bound);
        chk({nm, "_valid"}, 32'(res_valid), 1);
    endtask

    task automatic wait_clr(input int bound, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cntr_clr && n < bound);
        chk({nm, "_clr"}, 32'(cntr_clr), 1);
    endtask

    task automatic measure(input int bound, output int clr_n,
                           output int g_first, output int g_cnt,
                           output int v_n);
        clr_n = 0;
        g_first = 0;
        g_cnt = 0;
        v_n = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (cntr_clr && clr_n == 0) clr_n = n;
            if (gate) begin
                if (g_first == 0) g_first = n;
                g_cnt++;
            end
            if (res_valid) begin
                v_n = n;
                break;
            end
        end
    endtask

    // Monitor: pop and compare on every accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got ch %0d expected none",
                             res_ch);
                end else begin
                    e = sb.pop_front();
                    chk("res_ch", 32'(res_ch), 32'(e.ch));
                    chk("res_count", 32'(res_count), 32'(e.cnt));
                    chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        int c_n, g_f, g_c, v_n;
        logic bad;
        rst = 1'b1;
        enable = 1'b0;
        ch_mask = '0;
        gate_len = '0;
        res_ready = 1'b1;
        ovf_force = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_gate", 32'(gate), 0);
        chk("rst_clr", 32'(cntr_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_chsel", 32'(ch_sel), 0);
        chk("rst_res", {res_ch, res_count, res_ovf}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin over mask 0101 with timing checks.
        ch_mask = 4'b0101;
        gate_len = 16'd10;
        push(2'd0, 1'b0);
        push(2'd2, 1'b0);
        push(2'd0, 1'b0);
        push(2'd2, 1'b0);
        enable = 1'b1;
        measure(40, c_n, g_f, g_c, v_n);
        chk("t1_clr_at", c_n, 1);
        chk("t1_gate_first", g_f, 2);
        chk("t1_gate_len", g_c, 10);
        chk("t1_latency", v_n, 17);
        @(negedge clk);
        chk("t1_b2b_clr", 32'(cntr_clr), 1);
        chk("t1_b2b_ch", 32'(ch_sel), 2);
        wait_valid(40, "t1_r2");
        wait_valid(40, "t1_r3");
        wait_valid(40, "t1_r4");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_sb_drain", sb.size(), 0);

        // Gate length boundaries.
        ch_mask = 4'b0001;
        gate_len = 16'd0;
        push(2'd0, 1'b0);
        enable = 1'b1;
        measure(40, c_n, g_f, g_c, v_n);
        chk("t2_gate0_len", g_c, 1);
        chk("t2_gate0_lat", v_n, 8);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        ch_mask = 4'b0010;
        gate_len = 16'hFFFF;
        push(2'd1, 1'b0);
        enable = 1'b1;
        measure(70000, c_n, g_f, g_c, v_n);
        chk("t2_gatemax_len", g_c, 65535);
        chk("t2_gatemax_lat", v_n, 65542);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Stall in PRESENT with overflow on channel 3.
        ch_mask = 4'b1000;
        gate_len = 16'd3;
        res_ready = 1'b0;
        ovf_force = 1'b1;
        push(2'd3, 1'b1);
        enable = 1'b1;
        wait_valid(40, "t3");
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid || res_count != base(2'd3) ||
                res_ch != 2'd3 || !res_ovf || ch_sel != 2'd3 ||
                cntr_clr)
                bad = 1'b1;
        end
        chk("t3_hold", 32'(bad), 0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_next_clr", 32'(cntr_clr), 1);
        chk("t3_next_ch", 32'(ch_sel), 3);
        enable = 1'b0;
        ovf_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_abort_busy", 32'(busy), 0);

        // Abort mid-gate on channel 1, then resume with all channels.
        ch_mask = 4'b0010;
        gate_len = 16'd10;
        enable = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!gate && n < 20);
        end
        chk("t4_gate_on", 32'(gate), 1);
        chk("t4_ch", 32'(ch_sel), 1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("t4_gate_drop", 32'(gate), 0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || busy || gate) bad = 1'b1;
        end
        chk("t4_no_result", 32'(bad), 0);
        ch_mask = 4'b1111;
        push(2'd2, 1'b0);
        enable = 1'b1;
        wait_clr(10, "t4_resume");
        chk("t4_resume_ch", 32'(ch_sel), 2);
        wait_valid(40, "t4");
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Empty mask keeps the block idle.
        ch_mask = 4'b0000;
        enable = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || cntr_clr || gate) bad = 1'b1;
        end
        chk("t5_empty_idle", 32'(bad), 0);
        enable = 1'b0;

        // Reset while presenting, then first pick is channel 0.
        ch_mask = 4'b0101;
        gate_len = 16'd2;
        res_ready = 1'b0;
        enable = 1'b1;
        wait_valid(40, "t6");
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(res_valid), 0);
        chk("t6_rst_gate", 32'(gate), 0);
        chk("t6_rst_clr", 32'(cntr_clr), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        push(2'd0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_clr(10, "t6_restart");
        chk("t6_first_ch", 32'(ch_sel), 0);
        wait_valid(40, "t6_post");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
